// File: rtl/tt_um_nasser_hadi_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_nasser_hadi_serial_subtractor
// Purpose  : Bit-serial A - B, LSB first, borrow carried between beats.
//            Optional signed-overflow flag when SERSUB_SIGNED_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tt_um_nasser_hadi_serial_subtractor (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] C_MAX_BEATS = 4'd8;

    state_t      r_state, w_state_nxt;
    logic        r_d, w_d_nxt;
    logic        r_borrow, w_borrow_nxt;
    logic        r_out_valid, w_out_valid_nxt;
    logic        r_out_last, w_out_last_nxt;
    logic        r_done, w_done_nxt;
    logic        r_len_err, w_len_err_nxt;
    logic [3:0]  r_count, w_count_nxt;
    logic [7:0]  r_result, w_result_nxt;
    logic        w_ovf;

    logic w_a, w_b, w_in_valid, w_in_last, w_clear;
    logic w_start, w_bin, w_diff, w_bout;

    assign w_a        = ui_in[0];
    assign w_b        = ui_in[1];
    assign w_in_valid = ui_in[2];
    assign w_in_last  = ui_in[3];
    assign w_clear    = ui_in[4];

    wire w_unused = &{1'b0, ena, uio_in, ui_in[7:5]};

    // A beat accepted while no frame is open starts a fresh frame with zero borrow-in.
    assign w_start = w_in_valid && (r_state == ST_IDLE);
    assign w_bin   = w_start ? 1'b0 : r_borrow;
    assign w_diff  = w_a ^ w_b ^ w_bin;
    assign w_bout  = (~w_a & w_b) | (~(w_a ^ w_b) & w_bin);

`ifdef SERSUB_SIGNED_OVF_EN
    logic r_ovf, w_ovf_nxt;
    assign w_ovf = r_ovf;
`else
    assign w_ovf = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_d_nxt         = r_d;
        w_borrow_nxt    = r_borrow;
        w_out_valid_nxt = 1'b0;
        w_out_last_nxt  = 1'b0;
        w_done_nxt      = r_done;
        w_len_err_nxt   = r_len_err;
        w_count_nxt     = r_count;
        w_result_nxt    = r_result;
`ifdef SERSUB_SIGNED_OVF_EN
        w_ovf_nxt       = r_ovf;
`endif
        if (w_in_valid) begin
            w_state_nxt     = w_in_last ? ST_IDLE : ST_RUN;
            w_d_nxt         = w_diff;
            w_borrow_nxt    = w_bout;
            w_out_valid_nxt = 1'b1;
            w_out_last_nxt  = w_in_last;
            if (w_start) begin
                w_result_nxt  = 8'h00;
                w_count_nxt   = 4'd0;
                w_done_nxt    = 1'b0;
                w_len_err_nxt = 1'b0;
`ifdef SERSUB_SIGNED_OVF_EN
                w_ovf_nxt     = 1'b0;
`endif
            end
            // Beats past capacity only flag the error; the borrow chain still advances.
            if (w_count_nxt == C_MAX_BEATS) begin
                w_len_err_nxt = 1'b1;
            end else begin
                w_result_nxt[w_count_nxt[2:0]] = w_diff;
                w_count_nxt = w_count_nxt + 4'd1;
            end
            if (w_in_last) begin
                w_done_nxt = 1'b1;
`ifdef SERSUB_SIGNED_OVF_EN
                w_ovf_nxt  = (w_a ^ w_b) & (w_a ^ w_diff);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_clear) begin
            r_state     <= ST_IDLE;
            r_d         <= 1'b0;
            r_borrow    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_len_err   <= 1'b0;
            r_count     <= 4'd0;
            r_result    <= 8'h00;
`ifdef SERSUB_SIGNED_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_d         <= w_d_nxt;
            r_borrow    <= w_borrow_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_done      <= w_done_nxt;
            r_len_err   <= w_len_err_nxt;
            r_count     <= w_count_nxt;
            r_result    <= w_result_nxt;
`ifdef SERSUB_SIGNED_OVF_EN
            r_ovf       <= w_ovf_nxt;
`endif
        end
    end

    assign uo_out  = {(r_state == ST_RUN), r_len_err, w_ovf, r_done,
                      r_out_last, r_out_valid, r_borrow, r_d};
    assign uio_out = r_result;
    assign uio_oe  = 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_nasser_hadi_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_um_nasser_hadi_serial_subtractor
// Purpose  : Scoreboard bench for the serial subtractor; expectations come
//            from whole-word arithmetic on the bits streamed so far.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_um_nasser_hadi_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;
    logic [15:0] sbq[$];

    tt_um_nasser_hadi_serial_subtractor dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected {uo_out, uio_out} after beat k of an n-beat frame.
    function automatic logic [15:0] model(input int k, input int n,
                                          input logic [31:0] aw, input logic [31:0] bw);
        longint m, av, bv, dv, sa, sb, sd;
        logic   last, ovf;
        m    = (longint'(1) << (k + 1)) - 1;
        av   = longint'(aw) & m;
        bv   = longint'(bw) & m;
        dv   = (av - bv) & m;
        last = (k == n - 1);
        ovf  = 1'b0;
`ifdef SERSUB_SIGNED_OVF_EN
        if (last) begin
            sa  = av - (((av >> k) & 1) << (k + 1));
            sb  = bv - (((bv >> k) & 1) << (k + 1));
            sd  = sa - sb;
            ovf = (sd > ((longint'(1) << k) - 1)) || (sd < -(longint'(1) << k));
        end
`else
        sa = 0; sb = 0; sd = 0;
`endif
        return {~last, (k >= 8), ovf, last, last, 1'b1, (av < bv), dv[k], dv[7:0]};
    endfunction

    task automatic idle();
        logic [7:0] r;
        r      = 8'($urandom);
        ui_in  = {r[7:5], 1'b0, r[3], 1'b0, r[1:0]};
        uio_in = 8'($urandom);
        ena    = 1'($urandom);
    endtask

    task automatic beat(input logic a, input logic b, input logic last);
        logic [7:0] r;
        r      = 8'($urandom);
        ui_in  = {r[7:5], 1'b0, last, 1'b1, b, a};
        uio_in = 8'($urandom);
        ena    = 1'($urandom);
    endtask

    // Returns at the negedge after the last beat, while its outputs are visible.
    task automatic run_frame(input int n, input logic [31:0] aw, input logic [31:0] bw,
                             input int maxgap);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, maxgap)) begin
                @(negedge clk);
                idle();
            end
            @(negedge clk);
            beat(aw[k], bw[k], k == n - 1);
            sbq.push_back(model(k, n, aw, bw));
        end
        @(negedge clk);
        idle();
    endtask

    always @(posedge clk) begin
        #1;
        if (uo_out[2] === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got out_valid=1 expected 0");
            end else begin
                logic [15:0] e;
                e = sbq.pop_front();
                check("beat_uo_out", uo_out, e[15:8]);
                check("beat_uio_out", uio_out, e[7:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'hFF);
        rst_n = 1'b1;

        run_frame(4, 32'd5, 32'd3, 0);
        check("5m3_result", uio_out, 8'h02);
        check("5m3_borrow_done", {7'd0, uo_out[1]} | {3'd0, uo_out[4], 4'd0}, 8'h10);

        run_frame(4, 32'd3, 32'd5, 1);
        check("3m5_result", uio_out, 8'h0E);
        check("3m5_borrow", {7'd0, uo_out[1]}, 8'h01);

        run_frame(1, 32'd0, 32'd1, 0);
        check("0m1_flags", uo_out & 8'h9F, 8'h1F);

        run_frame(9, 32'h1FF, 32'h0, 0);
        check("len9_result", uio_out, 8'hFF);
        check("len9_len_err_borrow", uo_out & 8'h42, 8'h40);

        // Mid-frame soft clear, then a clean 6 - 1 frame.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            beat(1'b1, 1'b0, 1'b0);
            sbq.push_back(model(k, 4, 32'hF, 32'h0));
        end
        @(negedge clk);
        ui_in = 8'b0001_0111;
        @(posedge clk);
        #1;
        check("clear_uo_out", uo_out, 8'h00);
        check("clear_uio_out", uio_out, 8'h00);
        run_frame(3, 32'd6, 32'd1, 0);
        check("clr_6m1_result", uio_out, 8'h05);

        // Same scenario with reset instead of clear.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            beat(1'b0, 1'b1, 1'b0);
            sbq.push_back(model(k, 4, 32'h0, 32'hF));
        end
        @(negedge clk);
        rst_n = 1'b0;
        beat(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        run_frame(3, 32'd6, 32'd1, 0);
        check("rst_6m1_result", uio_out, 8'h05);

        run_frame(4, 32'd7, 32'd8, 0);
        check("ovf_result", uio_out, 8'h0F);
`ifdef SERSUB_SIGNED_OVF_EN
        check("ovf_flag", {7'd0, uo_out[5]}, 8'h01);
`else
        check("ovf_flag", {7'd0, uo_out[5]}, 8'h00);
`endif

        for (int f = 0; f < 60; f++) begin
            run_frame(int'($urandom_range(1, 12)), $urandom, $urandom, 2);
        end

        repeat (3) @(negedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL missing_beats: got %0d outstanding expected 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
